// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control sequencer: walks each instruction through its states and
// decodes datapath selects/strobes from the state register, with a memory-wait watchdog.
module mc_ctrl_fsm #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_read,
   output logic       mem_write,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_control,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       reg_write,
   output logic       instr_retired,
   output logic       halted,
   output logic       err,
   output logic [3:0] state
);
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_SRL   = 6'b000010;
   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   // The wait that would bring the count up to MEM_TIMEOUT is the one that halts.
   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);
   localparam logic       TIMEOUT_EN   = (MEM_TIMEOUT != 0);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB = 4'd7,
      S_IEXEC  = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JAL   = 4'd11,
      S_JR     = 4'd12, S_HALT   = 4'd13
   } state_t;

   state_t     state_r, state_next_s;
   logic [7:0] wait_cnt_r;
   logic       halted_r, err_r;
   logic       waiting_s, timeout_s;
   logic       mem_read_s, mem_write_s, ir_write_s, pc_write_s, reg_write_s, retire_s;

   function automatic logic [2:0] alu_from_funct(input logic [5:0] f);
      case (f)
         FN_SUB:  return ALU_SUB;
         FN_AND:  return 3'b000;
         FN_OR:   return 3'b001;
         FN_SLT:  return 3'b111;
         FN_SLL:  return 3'b100;
         FN_SRL:  return 3'b101;
         default: return ALU_ADD;
      endcase
   endfunction

   assign waiting_s = ((state_r == S_FETCH) || (state_r == S_MEMRD) || (state_r == S_MEMWR)) && !mem_ready;
   assign timeout_s = TIMEOUT_EN && waiting_s && (wait_cnt_r == TIMEOUT_LAST);

   // State, sticky status and watchdog registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= S_FETCH;
         halted_r   <= 1'b0;
         err_r      <= 1'b0;
         wait_cnt_r <= 8'd0;
      end else begin
         state_r    <= state_next_s;
         halted_r   <= halted_r | (state_next_s == S_HALT);
         err_r      <= err_r | timeout_s;
         if (state_next_s != state_r) begin
            wait_cnt_r <= 8'd0;
         end else if (waiting_s) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
         end else begin
            wait_cnt_r <= wait_cnt_r;
         end
      end
   end

   // Next-state sequencing
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         S_FETCH:  state_next_s = timeout_s ? S_HALT : (mem_ready ? S_DECODE : S_FETCH);
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW:   state_next_s = S_MEMADR;
               OP_ADDI:        state_next_s = S_IEXEC;
               OP_BEQ, OP_BNE: state_next_s = S_BRANCH;
               OP_JAL:         state_next_s = S_JAL;
               OP_RTYPE: begin
                  case (funct)
                     FN_ADD, FN_SUB, FN_AND, FN_OR,
                     FN_SLT, FN_SLL, FN_SRL: state_next_s = S_EXEC;
                     FN_JR:                  state_next_s = S_JR;
                     default:                state_next_s = S_HALT;
                  endcase
               end
               default:        state_next_s = S_HALT;
            endcase
         end
         S_MEMADR: state_next_s = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  state_next_s = timeout_s ? S_HALT : (mem_ready ? S_MEMWB : S_MEMRD);
         S_MEMWR:  state_next_s = timeout_s ? S_HALT : (mem_ready ? S_FETCH : S_MEMWR);
         S_EXEC:   state_next_s = S_ALUWB;
         S_IEXEC:  state_next_s = S_IWB;
         S_MEMWB, S_ALUWB, S_IWB, S_BRANCH, S_JAL, S_JR: state_next_s = S_FETCH;
         S_HALT:   state_next_s = S_HALT;
         default:  state_next_s = S_HALT;
      endcase
   end

   // Datapath control decode from the current state
   always_comb begin
      mem_read_s  = 1'b0;
      mem_write_s = 1'b0;
      ir_write_s  = 1'b0;
      pc_write_s  = 1'b0;
      reg_write_s = 1'b0;
      retire_s    = 1'b0;
      iord        = 1'b0;
      pc_src      = 2'b00;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      alu_control = 3'b000;
      reg_dst     = 2'b00;
      mem_to_reg  = 2'b00;
      case (state_r)
         S_FETCH: begin
            mem_read_s  = 1'b1;
            alu_src_b   = 2'b01;
            alu_control = ALU_ADD;
            ir_write_s  = mem_ready;
            pc_write_s  = mem_ready;
         end
         S_DECODE: begin
            alu_src_b   = 2'b11;
            alu_control = ALU_ADD;
         end
         S_MEMADR, S_IEXEC: begin
            alu_src_a   = 1'b1;
            alu_src_b   = 2'b10;
            alu_control = ALU_ADD;
         end
         S_MEMRD: begin
            mem_read_s = 1'b1;
            iord       = 1'b1;
         end
         S_MEMWB: begin
            mem_to_reg  = 2'b01;
            reg_write_s = 1'b1;
            retire_s    = 1'b1;
         end
         S_MEMWR: begin
            mem_write_s = 1'b1;
            iord        = 1'b1;
            retire_s    = mem_ready;
         end
         S_EXEC: begin
            alu_src_a   = 1'b1;
            alu_control = alu_from_funct(funct);
         end
         S_ALUWB: begin
            reg_dst     = 2'b01;
            reg_write_s = 1'b1;
            retire_s    = 1'b1;
         end
         S_IWB: begin
            reg_write_s = 1'b1;
            retire_s    = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a   = 1'b1;
            alu_control = ALU_SUB;
            pc_src      = 2'b01;
            pc_write_s  = (op == OP_BNE) ? ~zero : zero;
            retire_s    = 1'b1;
         end
         S_JAL: begin
            reg_dst     = 2'b10;
            mem_to_reg  = 2'b10;
            reg_write_s = 1'b1;
            pc_src      = 2'b10;
            pc_write_s  = 1'b1;
            retire_s    = 1'b1;
         end
         S_JR: begin
            pc_src     = 2'b11;
            pc_write_s = 1'b1;
            retire_s   = 1'b1;
         end
         default: begin
            retire_s = 1'b0;
         end
      endcase
   end

   // Strobes are squashed while reset is held so an aborted instruction writes nothing.
   assign mem_read      = mem_read_s  & ~reset;
   assign mem_write     = mem_write_s & ~reset;
   assign ir_write      = ir_write_s  & ~reset;
   assign pc_write      = pc_write_s  & ~reset;
   assign reg_write     = reg_write_s & ~reset;
   assign instr_retired = retire_s    & ~reset;
   assign halted        = halted_r;
   assign err           = err_r;
   assign state         = state_r;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-instruction expected output traces built from the instruction
// rules, checked cycle by cycle, plus literal cycle-count and status expectations.
module tb_mc_ctrl_fsm;
   localparam int TMO = 4;
   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011, OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_JAL = 6'b000011, OP_BAD = 6'b111111;
   localparam logic [5:0] F_SLL = 6'b000000, F_SRL = 6'b000010, F_JR = 6'b001000, F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010, F_AND = 6'b100100, F_OR = 6'b100101, F_SLT = 6'b101010;

   logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
   logic [5:0] op = 6'b0, funct = 6'b0;
   logic mem_read, mem_write, iord, ir_write, pc_write, alu_src_a, reg_write, instr_retired, halted, err;
   logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg;
   logic [2:0] alu_control;
   logic [3:0] state;

   typedef struct packed {
      logic mr, mw, iord, irw, pcw;
      logic [1:0] pcs;
      logic asa;
      logic [1:0] asb;
      logic [2:0] alu;
      logic [1:0] rd, m2r;
      logic rw, ret, hlt, er;
   } exp_t;

   exp_t q[$];
   exp_t act_s;
   int checks = 0, errors = 0, ncyc = 0;

   always #5 clk = ~clk;

   mc_ctrl_fsm #(.MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
      .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_control(alu_control), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .instr_retired(instr_retired), .halted(halted), .err(err),
      .state(state)
   );

   assign act_s = {mem_read, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                   alu_control, reg_dst, mem_to_reg, reg_write, instr_retired, halted, err};

   // Compare process: every queued expectation is matched on the falling edge of its cycle
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (act_s !== e) begin
            errors++;
            $display("FAIL trace t=%0t op=%b funct=%b act=%b exp=%b", $time, op, funct, act_s, e);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s act=%0d exp=%0d", name, act, exp);
      end
   endtask

   function automatic logic [2:0] alu_of(input logic [5:0] f);
      case (f)
         F_ADD:   return 3'b010;
         F_SUB:   return 3'b110;
         F_AND:   return 3'b000;
         F_OR:    return 3'b001;
         F_SLT:   return 3'b111;
         F_SLL:   return 3'b100;
         F_SRL:   return 3'b101;
         default: return 3'b010;
      endcase
   endfunction

   task automatic cyc(input exp_t e, input logic rdy);
      mem_ready = rdy;
      q.push_back(e);
      ncyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);
      chk("reset_strobes", int'({mem_read, mem_write, ir_write, pc_write, reg_write, instr_retired}), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic fetch(input int waits);
      exp_t e;
      e = '0; e.mr = 1'b1; e.asb = 2'b01; e.alu = 3'b010;
      for (int i = 0; i < waits; i++) cyc(e, 1'b0);
      e.irw = 1'b1; e.pcw = 1'b1;
      cyc(e, 1'b1);
   endtask

   task automatic decode();
      exp_t e;
      e = '0; e.asb = 2'b11; e.alu = 3'b010;
      cyc(e, 1'($urandom_range(1)));
   endtask

   task automatic addr_calc();
      exp_t e;
      e = '0; e.asa = 1'b1; e.asb = 2'b10; e.alu = 3'b010;
      cyc(e, 1'($urandom_range(1)));
   endtask

   task automatic halt_cycles(input int n, input logic er);
      exp_t e;
      e = '0; e.hlt = 1'b1; e.er = er;
      for (int i = 0; i < n; i++) begin
         op = 6'($urandom); funct = 6'($urandom); zero = 1'($urandom_range(1));
         cyc(e, 1'($urandom_range(1)));
      end
   endtask

   // Drive one instruction and queue the outputs each of its cycles must show
   task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z, input int fw, input int mw);
      exp_t e;
      bit rtype_ok;
      op = o; funct = f; zero = z; ncyc = 0;
      rtype_ok = (f == F_ADD) || (f == F_SUB) || (f == F_AND) || (f == F_OR) ||
                 (f == F_SLT) || (f == F_SLL) || (f == F_SRL);
      fetch(fw);
      decode();
      e = '0;
      if (o == OP_LW) begin
         addr_calc();
         e.mr = 1'b1; e.iord = 1'b1;
         for (int i = 0; i < mw; i++) cyc(e, 1'b0);
         cyc(e, 1'b1);
         e = '0; e.m2r = 2'b01; e.rw = 1'b1; e.ret = 1'b1;
         cyc(e, 1'($urandom_range(1)));
      end else if (o == OP_SW) begin
         addr_calc();
         e.mw = 1'b1; e.iord = 1'b1;
         for (int i = 0; i < mw; i++) cyc(e, 1'b0);
         e.ret = 1'b1;
         cyc(e, 1'b1);
      end else if (o == OP_ADDI) begin
         addr_calc();
         e.rw = 1'b1; e.ret = 1'b1;
         cyc(e, 1'($urandom_range(1)));
      end else if (o == OP_BEQ || o == OP_BNE) begin
         e.asa = 1'b1; e.alu = 3'b110; e.pcs = 2'b01; e.ret = 1'b1;
         e.pcw = (o == OP_BEQ) ? z : ~z;
         cyc(e, 1'($urandom_range(1)));
      end else if (o == OP_JAL) begin
         e.rd = 2'b10; e.m2r = 2'b10; e.rw = 1'b1; e.pcs = 2'b10; e.pcw = 1'b1; e.ret = 1'b1;
         cyc(e, 1'($urandom_range(1)));
      end else if (o == OP_R && f == F_JR) begin
         e.pcs = 2'b11; e.pcw = 1'b1; e.ret = 1'b1;
         cyc(e, 1'($urandom_range(1)));
      end else if (o == OP_R && rtype_ok) begin
         e.asa = 1'b1; e.alu = alu_of(f);
         cyc(e, 1'($urandom_range(1)));
         e = '0; e.rd = 2'b01; e.rw = 1'b1; e.ret = 1'b1;
         cyc(e, 1'($urandom_range(1)));
      end else begin
         halt_cycles(20, 1'b0);
      end
   endtask

   initial begin
      logic [5:0] alu_fns [6];
      alu_fns = '{F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_SRL};
      do_reset();
      run(OP_R, F_ADD, 1'b0, 0, 0);   chk("cpi_add", ncyc, 4);
      run(OP_LW, 6'b010101, 1'b0, 0, 3); chk("cyc_lw_wait3", ncyc, 8);
      run(OP_BEQ, 6'b0, 1'b1, 0, 0);  chk("cpi_beq", ncyc, 3);
      run(OP_BNE, 6'b0, 1'b1, 0, 0);  chk("cpi_bne", ncyc, 3);
      run(OP_BEQ, 6'b0, 1'b0, 0, 0);
      run(OP_BNE, 6'b0, 1'b0, 0, 0);
      run(OP_JAL, 6'b0, 1'b0, 0, 0);  chk("cpi_jal", ncyc, 3);
      run(OP_R, F_JR, 1'b0, 0, 0);    chk("cpi_jr", ncyc, 3);
      run(OP_ADDI, 6'b0, 1'b0, 0, 0); chk("cpi_addi", ncyc, 4);
      run(OP_SW, 6'b0, 1'b0, 3, 3);   chk("cyc_sw_waits", ncyc, 10);
      run(OP_LW, 6'b0, 1'b0, 0, 0);   chk("cpi_lw", ncyc, 5);
      foreach (alu_fns[i]) run(OP_R, alu_fns[i], 1'b0, 0, 0);

      run(OP_BAD, 6'b0, 1'b0, 0, 0);  chk("cyc_illegal", ncyc, 22);
      chk("illegal_halted", int'(halted), 1);
      chk("illegal_err", int'(err), 0);
      do_reset();
      chk("reset_clears_halted", int'(halted), 0);
      run(OP_R, F_ADD, 1'b0, 0, 0);
      run(OP_R, 6'b000001, 1'b0, 0, 0);
      chk("bad_funct_halted", int'(halted), 1);
      do_reset();

      // Memory never answers during fetch: watchdog trips
      begin
         exp_t e;
         op = OP_R; funct = F_ADD;
         e = '0; e.mr = 1'b1; e.asb = 2'b01; e.alu = 3'b010;
         for (int i = 0; i < TMO; i++) cyc(e, 1'b0);
         halt_cycles(5, 1'b1);
         chk("timeout_err", int'(err), 1);
         chk("timeout_halted", int'(halted), 1);
      end
      do_reset();
      chk("reset_clears_err", int'(err), 0);

      // Reset lands mid-store
      op = OP_SW; funct = 6'b0;
      fetch(0);
      decode();
      addr_calc();
      do_reset();
      run(OP_R, F_OR, 1'b0, 0, 0);

      @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
endmodule
